issue_scheduler: RTL and testbench
==================================

ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 Parameter: QDEPTH, default 4, instruction queue entries; fixed power of two >= 4.
REQ-002 Port: clk  input  1  sole clock, all state on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: fetch_count  input  2  instructions offered this cycle (0, 1 or 2); value 3 treated as 2.
REQ-005 Port: fetch_inst0, fetch_inst1  input  32 each  offered instructions, program order inst0 first.
REQ-006 Port: fetch_pc0  input  32  PC of fetch_inst0; fetch_inst1 PC is fetch_pc0+4 (mod 2^32).
REQ-007 Port: fetch_ready  output  1  queue accepts up to 2 instructions this cycle.
REQ-008 Port: issue_ready  input  1  pipeline accepts issued instructions this cycle.
REQ-009 Port: issue0_valid, issue1_valid  output  1 each  slot 0 / slot 1 carries an instruction.
REQ-010 Port: issue0_inst, issue1_inst  output  32 each  issued instruction words.
REQ-011 Port: issue0_pc, issue1_pc  output  32 each  issued PCs.
REQ-012 Port: flush  input  1  taken branch/jump redirect; discard all queued instructions.
REQ-013 Port: occupancy  output  3  current entry count (0..QDEPTH).

Function
REQ-014 Queue SHALL be circular: head/tail pointers wrap modulo QDEPTH; count register 0..QDEPTH.
REQ-015 fetch_ready SHALL be 1 iff count <= QDEPTH-2, derived from registered count only (no issue-side combinational path).
REQ-016 Enqueue when fetch_ready=1 and fetch_count>0: fetch_count entries written at tail, inst0 first; fetch_count ignored when fetch_ready=0.
REQ-017 Enqueued instruction SHALL be visible on issue outputs no earlier than the next cycle (1-cycle minimum latency, no bypass).
REQ-018 Classification from each entry's opcode bits [6:2]: MEM = 00000/01000; CTRL = 11000/11011/11001; WRITES_RD = all except 11000/01000; READS_RS2 = 11000/01000/01100; READS_RS1 = all except 01101/00101/11011.
REQ-019 issue0_valid SHALL equal (count >= 1); slot 0 always holds the head entry.
REQ-020 issue1_valid SHALL be 1 iff count >= 2 and all pairing rules hold for head (A) and head+1 (B):
- A not CTRL;
- not (A MEM and B MEM);
- no RAW: if A WRITES_RD and rd(A)!=0, rd(A) differs from rs1(B) when B READS_RS1 and from rs2(B) when B READS_RS2;
- no WAW: not (both WRITES_RD, rd(A)=rd(B)!=0).
REQ-021 Entries with inst[1:0]!=11, or opcodes outside REQ-018 plus 00100/01100/01101/00101, SHALL issue alone in slot 0 (never paired, never in slot 1).
REQ-022 Dequeue on issue_ready=1: head advances by issue0_valid+issue1_valid; issue_ready=0 holds outputs stable.
REQ-023 Same-cycle enqueue and dequeue: count_next = count + enq - deq; never exceeds QDEPTH nor underflows.
REQ-024 flush=1 SHALL set count, head and tail to 0 next cycle; same-cycle enqueue/dequeue ignored; flush has priority.
REQ-025 Issue outputs SHALL be combinational from registered queue state only; inst/pc values when valid=0 are don't-care.
REQ-026 occupancy SHALL equal registered count.

Reset
REQ-027 rst_n=0 SHALL immediately clear count, head, tail; issue0_valid=issue1_valid=0, fetch_ready=1, occupancy=0, regardless of clock.
REQ-028 Queue storage need not be reset; reset mid-operation discards all entries; first instruction after release issues no earlier than 1 cycle after enqueue.

Verification
REQ-029 Reset, enqueue addi x1,x0,1 and addi x2,x0,2 (pc 0x100) -> next cycle issue0/1_valid=1, pcs 0x100/0x104; issue_ready=1 -> occupancy 0.
REQ-030 Enqueue addi x1,x0,1 then add x3,x1,x1 -> issue1_valid=0 (RAW); second issues alone next cycle.
REQ-031 Enqueue lw x5,0(x2) then sw x6,4(x2) -> not paired (two MEM); beq x0,x0,8 then addi -> not paired (CTRL in slot 0).
REQ-032 issue_ready=0, enqueue 2 per cycle -> fetch_ready drops when occupancy=3, occupancy stops at 4; release -> FIFO order preserved across pointer wrap.
REQ-033 Queue full, assert flush with fetch_count=2 and issue_ready=1 -> next cycle occupancy=0, both valids 0, fetch_ready=1.
REQ-034 rst_n asserted between clock edges with occupancy 3 -> valids drop immediately, occupancy 0 before next edge.

Source files
------------

// File: rtl/issue_scheduler.sv
// issue_scheduler: circular instruction queue with dual-issue pairing
//   clk, rst_n                 clock, async active-low reset
//   fetch_count/inst0/inst1/pc0 up to two fetched instructions per cycle
//   fetch_ready                queue can take two more entries
//   issue_ready                pipeline consumes the issued slots
//   issue{0,1}_valid/inst/pc   head entry (slot 0) and optional paired entry (slot 1)
//   flush                      discard everything queued
//   occupancy                  registered entry count
module issue_scheduler #(
   parameter int QDEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  fetch_count,
   input  logic [31:0] fetch_inst0,
   input  logic [31:0] fetch_inst1,
   input  logic [31:0] fetch_pc0,
   output logic        fetch_ready,
   input  logic        issue_ready,
   output logic        issue0_valid,
   output logic        issue1_valid,
   output logic [31:0] issue0_inst,
   output logic [31:0] issue1_inst,
   output logic [31:0] issue0_pc,
   output logic [31:0] issue1_pc,
   input  logic        flush,
   output logic [2:0]  occupancy
);
   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;
   logic [31:0]   inst_q [QDEPTH];
   logic [31:0]   pc_q   [QDEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d, head1, tail1;
   logic [CW-1:0] count_q, count_d;
   logic [1:0]    enq_n, deq_n;
   function automatic logic legal(input logic [31:0] i);
      return i[1:0] == 2'b11 && i[6:2] inside {5'b00000, 5'b01000, 5'b11000, 5'b11011, 5'b11001,
                                               5'b00100, 5'b01100, 5'b01101, 5'b00101};
   endfunction
   function automatic logic is_mem(input logic [4:0] op);
      return op == 5'b00000 || op == 5'b01000;
   endfunction
   function automatic logic writes_rd(input logic [4:0] op);
      return !(op == 5'b11000 || op == 5'b01000);
   endfunction
   function automatic logic pair_ok(input logic [31:0] a, input logic [31:0] b);
      logic [4:0] oa, ob;
      logic       raw, waw;
      oa  = a[6:2];
      ob  = b[6:2];
      raw = writes_rd(oa) && a[11:7] != 5'd0 &&
            ((!(ob inside {5'b01101, 5'b00101, 5'b11011}) && a[11:7] == b[19:15]) ||
             (ob inside {5'b11000, 5'b01000, 5'b01100} && a[11:7] == b[24:20]));
      waw = writes_rd(oa) && writes_rd(ob) && a[11:7] == b[11:7] && a[11:7] != 5'd0;
      return legal(a) && legal(b) && !(oa inside {5'b11000, 5'b11011, 5'b11001}) &&
             !(is_mem(oa) && is_mem(ob)) && !raw && !waw;
   endfunction
   assign head1 = head_q + 1'b1;
   assign tail1 = tail_q + 1'b1;
   always_comb begin
      fetch_ready  = count_q <= CW'(QDEPTH - 2);
      // fetch_count of 3 is treated as 2
      enq_n        = fetch_ready ? (fetch_count[1] ? 2'd2 : {1'b0, fetch_count[0]}) : 2'd0;
      issue0_valid = count_q != '0;
      issue1_valid = count_q >= CW'(2) && pair_ok(inst_q[head_q], inst_q[head1]);
      issue0_inst  = inst_q[head_q];
      issue1_inst  = inst_q[head1];
      issue0_pc    = pc_q[head_q];
      issue1_pc    = pc_q[head1];
      deq_n        = issue_ready ? {1'b0, issue0_valid} + {1'b0, issue1_valid} : 2'd0;
      head_d       = flush ? '0 : head_q + PW'(deq_n);
      tail_d       = flush ? '0 : tail_q + PW'(enq_n);
      count_d      = flush ? '0 : count_q + CW'(enq_n) - CW'(deq_n);
      occupancy    = 3'(count_q);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end
   // storage is not reset; count gates visibility of stale contents
   always_ff @(posedge clk) begin
      if (enq_n != 2'd0) begin
         inst_q[tail_q] <= fetch_inst0;
         pc_q[tail_q]   <= fetch_pc0;
      end
      if (enq_n == 2'd2) begin
         inst_q[tail1] <= fetch_inst1;
         pc_q[tail1]   <= fetch_pc0 + 32'd4;
      end
   end
endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: scoreboard-driven bench for issue_scheduler
module tb_issue_scheduler;
   localparam logic [31:0] ADDI1 = 32'h00100093; // addi x1,x0,1
   localparam logic [31:0] ADDI2 = 32'h00200113; // addi x2,x0,2
   localparam logic [31:0] ADDI1B = 32'h00200093; // addi x1,x0,2
   localparam logic [31:0] ADD31 = 32'h001081B3; // add x3,x1,x1
   localparam logic [31:0] LW = 32'h00012283; // lw x5,0(x2)
   localparam logic [31:0] SW = 32'h00612223; // sw x6,4(x2)
   localparam logic [31:0] BEQ = 32'h00000463; // beq x0,x0,8
   logic clk = 0, rst_n = 0, fetch_ready, issue_ready = 0, flush = 0;
   logic issue0_valid, issue1_valid;
   logic [1:0] fetch_count = 0;
   logic [31:0] fetch_inst0 = 0, fetch_inst1 = 0, fetch_pc0 = 0;
   logic [31:0] issue0_inst, issue1_inst, issue0_pc, issue1_pc;
   logic [2:0] occupancy;
   typedef struct {logic [31:0] pc; logic [31:0] inst;} ent_t;
   ent_t sb[$];
   int tests = 0, fails = 0, kk = 1;
   logic [31:0] pcv = 32'h1000;
   issue_scheduler dut (
      .clk(clk), .rst_n(rst_n), .fetch_count(fetch_count), .fetch_inst0(fetch_inst0),
      .fetch_inst1(fetch_inst1), .fetch_pc0(fetch_pc0), .fetch_ready(fetch_ready),
      .issue_ready(issue_ready), .issue0_valid(issue0_valid), .issue1_valid(issue1_valid),
      .issue0_inst(issue0_inst), .issue1_inst(issue1_inst), .issue0_pc(issue0_pc),
      .issue1_pc(issue1_pc), .flush(flush), .occupancy(occupancy));
   always #5 clk = ~clk;
   function automatic logic [31:0] addi(input int k);
      return {12'(k), 5'd0, 3'd0, 5'((k % 31) + 1), 7'h13};
   endfunction
   task automatic set(input logic [1:0] n, input logic [31:0] pc, input logic [31:0] i0,
                      input logic [31:0] i1, input logic ir);
      fetch_count = n; fetch_pc0 = pc; fetch_inst0 = i0; fetch_inst1 = i1; issue_ready = ir;
   endtask
   task automatic set_seq(input logic [1:0] n, input logic ir);
      set(n, pcv, addi(kk), addi(kk + 1), ir);
      if (n != 0) begin pcv += 8; kk += 2; end
   endtask
   // compare current outputs with the scoreboard, clock once, then update the model
   task automatic step(input bit pair_allowed);
      bit ev0, ev1, er, f;
      int enq, deq;
      logic [31:0] pc, i0, i1;
      ev0 = sb.size() >= 1;
      ev1 = sb.size() >= 2 && pair_allowed;
      er = sb.size() <= 2;
      tests++;
      if (issue0_valid !== ev0) begin fails++; $display("FAIL v0 got %b exp %b", issue0_valid, ev0); end
      tests++;
      if (issue1_valid !== ev1) begin fails++; $display("FAIL v1 got %b exp %b", issue1_valid, ev1); end
      tests++;
      if (fetch_ready !== er) begin fails++; $display("FAIL fetch_ready got %b exp %b", fetch_ready, er); end
      tests++;
      if (occupancy !== 3'(sb.size())) begin
         fails++; $display("FAIL occupancy got %0d exp %0d", occupancy, sb.size());
      end
      if (ev0) begin
         tests++;
         if (issue0_pc !== sb[0].pc || issue0_inst !== sb[0].inst) begin
            fails++; $display("FAIL slot0 got %h/%h exp %h/%h", issue0_pc, issue0_inst, sb[0].pc, sb[0].inst);
         end
      end
      if (ev1) begin
         tests++;
         if (issue1_pc !== sb[1].pc || issue1_inst !== sb[1].inst) begin
            fails++; $display("FAIL slot1 got %h/%h exp %h/%h", issue1_pc, issue1_inst, sb[1].pc, sb[1].inst);
         end
      end
      deq = issue_ready ? int'(ev0) + int'(ev1) : 0;
      enq = er ? (fetch_count == 0 ? 0 : fetch_count == 1 ? 1 : 2) : 0;
      f = flush; pc = fetch_pc0; i0 = fetch_inst0; i1 = fetch_inst1;
      @(posedge clk); #1;
      if (f) sb.delete();
      else begin
         repeat (deq) void'(sb.pop_front());
         if (enq >= 1) sb.push_back('{pc, i0});
         if (enq == 2) sb.push_back('{pc + 32'd4, i1});
      end
   endtask
   task automatic test_reset();
      #1;
      tests++;
      if (issue0_valid !== 0 || issue1_valid !== 0 || fetch_ready !== 1 || occupancy !== 0) begin
         fails++; $display("FAIL reset got v0=%b v1=%b rdy=%b occ=%0d exp 0 0 1 0",
                           issue0_valid, issue1_valid, fetch_ready, occupancy);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
   endtask
   task automatic test_pair();
      set(2, 32'h100, ADDI1, ADDI2, 1); step(0);
      set(0, 0, 0, 0, 1); step(1);
      tests++;
      if (occupancy !== 0) begin fails++; $display("FAIL pair_drain occ got %0d exp 0", occupancy); end
   endtask
   task automatic test_raw();
      set(2, 32'h200, ADDI1, ADD31, 1); step(0);
      set(0, 0, 0, 0, 1); step(0); step(0);
   endtask
   task automatic test_solo();
      set(2, 32'h300, LW, SW, 1); step(0);
      set(0, 0, 0, 0, 1); step(0); step(0);
      set(2, 32'h340, BEQ, ADDI1, 1); step(0);
      set(0, 0, 0, 0, 1); step(0); step(0);
      set(2, 32'h380, ADDI1, 32'h0, 1); step(0);
      set(0, 0, 0, 0, 1); step(0); step(0);
      set(2, 32'h3c0, 32'h0, ADDI1, 1); step(0);
      set(0, 0, 0, 0, 1); step(0); step(0);
      set(2, 32'h400, ADDI1, ADDI1B, 1); step(0);
      set(0, 0, 0, 0, 1); step(0); step(0);
   endtask
   task automatic test_full_wrap();
      set_seq(2, 0); step(1);
      set_seq(3, 0); step(1);
      set(2, 32'hdead, ADDI1, ADDI2, 0); step(1);
      tests++;
      if (occupancy !== 4 || fetch_ready !== 0) begin
         fails++; $display("FAIL full got occ=%0d rdy=%b exp 4 0", occupancy, fetch_ready);
      end
      set(0, 0, 0, 0, 1); step(1);
      for (int i = 0; i < 6; i++) begin set_seq(2, 1); step(1); end
      set(0, 0, 0, 0, 1); for (int i = 0; i < 3; i++) step(1);
      set_seq(1, 0); step(1);
      set_seq(2, 0); step(1);
      set(2, 32'hbeef, ADDI1, ADDI2, 0); step(1);
      set(0, 0, 0, 0, 1); for (int i = 0; i < 3; i++) step(1);
   endtask
   task automatic test_flush();
      set_seq(2, 0); step(1);
      set_seq(2, 0); step(1);
      set(2, 32'h900, ADDI1, ADDI2, 1); flush = 1; step(1);
      flush = 0; set(0, 0, 0, 0, 1);
      tests++;
      if (occupancy !== 0 || issue0_valid !== 0 || issue1_valid !== 0 || fetch_ready !== 1) begin
         fails++; $display("FAIL flush got occ=%0d v0=%b v1=%b rdy=%b exp 0 0 0 1",
                           occupancy, issue0_valid, issue1_valid, fetch_ready);
      end
      step(1);
   endtask
   task automatic test_async_reset();
      set_seq(2, 0); step(1);
      set_seq(1, 0); step(1);
      set(0, 0, 0, 0, 0);
      tests++;
      if (occupancy !== 3) begin fails++; $display("FAIL pre_reset occ got %0d exp 3", occupancy); end
      #2 rst_n = 0;
      #1;
      tests++;
      if (issue0_valid !== 0 || issue1_valid !== 0 || fetch_ready !== 1 || occupancy !== 0) begin
         fails++; $display("FAIL async_reset got v0=%b v1=%b rdy=%b occ=%0d exp 0 0 1 0",
                           issue0_valid, issue1_valid, fetch_ready, occupancy);
      end
      sb.delete();
      #1 rst_n = 1;
      @(posedge clk); #1;
      set_seq(2, 1); step(1);
      set(0, 0, 0, 0, 1); step(1); step(1);
   endtask
   initial begin
      test_reset();
      test_pair();
      test_raw();
      test_solo();
      test_full_wrap();
      test_flush();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
